// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared constants and helpers for the percent-controlled PWM generator.
//   PERCENT_MAX : full-scale duty request (100 %), also the number of steps
//   STEP_W      : width of the duty step counter (0..99)
//   DUTY_W      : width of the duty request / compare path
//   clamp_duty  : limits a raw request to 0..PERCENT_MAX
`timescale 1ns/1ps

package pwm_pkg;

    localparam int PERCENT_MAX = 100;
    localparam int STEP_W      = 7;
    localparam int DUTY_W      = 8;

    // Requests above 100 % saturate to 100 %, which keeps the output
    // constantly high instead of wrapping to some odd duty.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] req);
        if (req > DUTY_W'(PERCENT_MAX)) begin
            return DUTY_W'(PERCENT_MAX);
        end
        return req;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
// Divides the system clock into duty steps of CLK_DIV clocks each.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clear in  synchronous clear, holds the count at 0 while high
//   tick  out high in the last clock of a step (count == CLK_DIV-1)
//   zero  out high in the first clock of a step (count == 0)
`timescale 1ns/1ps

module pwm_prescaler #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic zero
);

    // A divider of 1 still needs a one-bit counter that simply stays at 0.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);
    assign zero = (div_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_module.sv
// pwm_module
// Percent-controlled PWM generator. The period is PERCENT_MAX duty steps of
// CLK_DIV clocks each; the output is high for the first duty_eff steps.
// Ports:
//   I_clk        in  system clock, rising edge
//   I_rst_n      in  asynchronous active-low reset
//   I_en         in  enable; low holds counters at 0 and forces O_PWM low
//   I_PWM_percen in  duty request in percent, values above 100 clamp to 100
//   O_PWM        out registered PWM output
`timescale 1ns/1ps

module pwm_module
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_en,
    input  logic [DUTY_W-1:0] I_PWM_percen,
    output logic              O_PWM
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERCENT_MAX - 1);

    logic              tick;
    logic              div_zero;
    logic [STEP_W-1:0] step;
    logic [DUTY_W-1:0] duty_in;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_eff;
    logic              period_start;
    logic              pwm_next;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .clear (!I_en),
        .tick  (tick),
        .zero  (div_zero)
    );

    assign duty_in      = clamp_duty(I_PWM_percen);
    assign period_start = div_zero && (step == '0);

    // In the period-start cycle the live request is used directly so a
    // request arriving exactly at the boundary applies to this period; the
    // rest of the period runs from the shadow copy and cannot glitch.
    assign duty_eff = period_start ? duty_in : duty_q;
    assign pwm_next = I_en && ({1'b0, step} < duty_eff);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            step <= '0;
        end else if (!I_en) begin
            step <= '0;
        end else if (tick) begin
            step <= (step == STEP_LAST) ? '0 : step + STEP_W'(1);
        end
    end

    // While disabled the counters sit at 0, so every cycle is a period start
    // and the shadow keeps tracking the request.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            duty_q <= '0;
        end else if (period_start) begin
            duty_q <= duty_in;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_PWM <= 1'b0;
        end else begin
            O_PWM <= pwm_next;
        end
    end

endmodule

// File: tb/tb_pwm_module.sv
// tb_pwm_module
// Directed bench for pwm_module with CLK_DIV=4 (400-clock period).
// Table vectors restart the generator with a given request and check the
// high time and the position of the first low sample over two periods;
// hand-written sequences cover reset, mid-period changes, enable drop and
// asynchronous reset.
`timescale 1ns/1ps

module tb_pwm_module;

    localparam int CLK_DIV = 4;
    localparam int PERIOD  = 100 * CLK_DIV;
    localparam int NVEC    = 9;
    localparam int NRAMP   = 9;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b0;
    logic [7:0] percen = 8'd0;
    logic       pwm;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] percen;
        int         exp_high;
        int         exp_first_low;
    } vec_t;

    vec_t vecs[NVEC];
    int   ramp_vals[NRAMP];

    always #5 clk = ~clk;

    pwm_module #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_en         (en),
        .I_PWM_percen (percen),
        .O_PWM        (pwm)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Samples one period starting with the edge that ends a period-start
    // cycle. If change_at >= 0 the request is switched to new_p right after
    // sample change_at.
    task automatic measure(input int change_at, input logic [7:0] new_p,
                           output int high, output int first_low);
        high      = 0;
        first_low = PERIOD;
        for (int i = 0; i < PERIOD; i++) begin
            next_edge();
            if (pwm === 1'b1) begin
                high++;
            end else if (first_low == PERIOD) begin
                first_low = i;
            end
            if (i == change_at) begin
                percen = new_p;
            end
        end
    endtask

    // Drop enable for two edges, then re-enable with request p; the next
    // edge is the first enabled one and starts a period.
    task automatic restart(input logic [7:0] p);
        next_edge();
        en = 1'b0;
        next_edge();
        next_edge();
        check("disabled_low", int'(pwm), 0);
        percen = p;
        en     = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int f;

        vecs[0] = '{8'd25,  100, 100};
        vecs[1] = '{8'd0,   0,   0};
        vecs[2] = '{8'd100, 400, 400};
        vecs[3] = '{8'd150, 400, 400};
        vecs[4] = '{8'd1,   4,   4};
        vecs[5] = '{8'd99,  396, 396};
        vecs[6] = '{8'd50,  200, 200};
        vecs[7] = '{8'd255, 400, 400};
        vecs[8] = '{8'd101, 400, 400};

        ramp_vals = '{10, 11, 12, 98, 99, 100, 99, 0, 1};

        // Reset held for 100 ns with enable and 25 % already applied.
        en     = 1'b1;
        percen = 8'd25;
        for (int i = 0; i < 3; i++) begin
            next_edge();
            check("reset_low", int'(pwm), 0);
        end
        wait ($time >= 96);
        #6;
        rst_n = 1'b1;
        measure(-1, 8'd0, h, f);
        check("reset_p0_high", h, 100);
        check("reset_p0_first_low", f, 100);
        measure(-1, 8'd0, h, f);
        check("reset_p1_high", h, 100);
        check("reset_p1_first_low", f, 100);

        // Table-driven duty vectors.
        for (int v = 0; v < NVEC; v++) begin
            restart(vecs[v].percen);
            measure(-1, 8'd0, h, f);
            check($sformatf("vec%0d_p0_high", v), h, vecs[v].exp_high);
            check($sformatf("vec%0d_p0_first_low", v), f, vecs[v].exp_first_low);
            measure(-1, 8'd0, h, f);
            check($sformatf("vec%0d_p1_high", v), h, vecs[v].exp_high);
        end

        // 0 % with a mid-period switch to 100 %: stays low, then high with no
        // low cycle across two wraps.
        restart(8'd0);
        measure(200, 8'd100, h, f);
        check("zero_then_full_p0_high", h, 0);
        measure(-1, 8'd0, h, f);
        check("zero_then_full_p1_high", h, 400);
        measure(-1, 8'd0, h, f);
        check("zero_then_full_p2_high", h, 400);

        // Ramp with changes at period clock 200; the 99 -> 0 step is applied
        // in the period-start cycle itself and must take effect immediately.
        restart(ramp_vals[0][7:0]);
        for (int p = 0; p < NRAMP; p++) begin
            int at;
            at = -1;
            if (p < NRAMP - 1) begin
                at = (p == 6) ? PERIOD - 1 : 200;
            end
            measure(at, (p < NRAMP - 1) ? ramp_vals[p+1][7:0] : 8'd0, h, f);
            check($sformatf("ramp%0d_high", p), h, 4 * ramp_vals[p]);
            check($sformatf("ramp%0d_first_low", p), f, 4 * ramp_vals[p]);
        end

        // Enable dropped during the high phase.
        restart(8'd50);
        for (int i = 0; i < 100; i++) begin
            next_edge();
        end
        check("en_pre_drop_high", int'(pwm), 1);
        en = 1'b0;
        next_edge();
        check("en_fall_low", int'(pwm), 0);
        percen = 8'd80;
        next_edge();
        next_edge();
        check("en_off_low", int'(pwm), 0);
        percen = 8'd50;
        en     = 1'b1;
        measure(-1, 8'd0, h, f);
        check("en_restore_high", h, 200);
        check("en_restore_first_low", f, 200);

        // Asynchronous reset between edges in the middle of a high phase.
        restart(8'd50);
        for (int i = 0; i < 50; i++) begin
            next_edge();
        end
        check("pre_areset_high", int'(pwm), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_immediate_low", int'(pwm), 0);
        percen = 8'd30;
        next_edge();
        check("areset_held_low", int'(pwm), 0);
        next_edge();
        #2;
        rst_n = 1'b1;
        measure(-1, 8'd0, h, f);
        check("areset_restart_high", h, 120);
        check("areset_restart_first_low", f, 120);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
